// File: rtl/input_conditioner_if.sv
// Raw button/strobe inputs in, debounced levels and rising-edge pulses out.
interface input_conditioner_if;
    logic aRaw;
    logic bRaw;
    logic a;
    logic b;
    logic aRise;
    logic bRise;

    modport master (output aRaw, bRaw, input a, b, aRise, bRise);
    modport slave  (input aRaw, bRaw, output a, b, aRise, bRise);
endinterface

// File: rtl/input_conditioner.sv
// Two independent lanes: synchronizer chain -> debounce FSM -> registered level
// and single-cycle rising-edge pulse.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input_conditioner_if.slave    io
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        RISING,
        STABLE_HIGH,
        FALLING
    } state_t;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] lvl;
    logic [NUM_LANES-1:0] rise;

    assign raw = {io.bRaw, io.aRaw};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt;
        state_t                 st;
        logic                   lvl_r;
        logic                   rise_r;
        logic                   seen;

        assign seen = sync[SYNC_STAGES-1];

        // The counter tracks consecutive cycles the synchronized input has
        // disagreed with the committed level; any agreement restarts it.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                sync   <= '0;
                cnt    <= '0;
                st     <= STABLE_LOW;
                lvl_r  <= 1'b0;
                rise_r <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], raw[g]};
                rise_r <= 1'b0;
                case (st)
                    STABLE_LOW: begin
                        if (seen) begin
                            cnt <= CW'(1);
                            st  <= RISING;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    RISING: begin
                        if (!seen) begin
                            cnt <= '0;
                            st  <= STABLE_LOW;
                        end else if (cnt == LIM) begin
                            lvl_r  <= 1'b1;
                            rise_r <= 1'b1;
                            cnt    <= '0;
                            st     <= STABLE_HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!seen) begin
                            cnt <= CW'(1);
                            st  <= FALLING;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    FALLING: begin
                        if (seen) begin
                            cnt <= '0;
                            st  <= STABLE_HIGH;
                        end else if (cnt == LIM) begin
                            lvl_r <= 1'b0;
                            cnt   <= '0;
                            st    <= STABLE_LOW;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt <= '0;
                        st  <= STABLE_LOW;
                    end
                endcase
            end
        end

        assign lvl[g]  = lvl_r;
        assign rise[g] = rise_r;
    end

    assign io.a     = lvl[0];
    assign io.b     = lvl[1];
    assign io.aRise = rise[0];
    assign io.bRise = rise[1];
endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a run-length
// debounce model fed through a raw-sample delay log.
module tb_input_conditioner;
    localparam int D = 4;
    localparam int S = 2;

    logic clk;
    logic rstN;
    input_conditioner_if ifc ();

    input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rstN (rstN),
        .io   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a channel flips when the input it sees (raw delayed S edges)
    // has differed from its level for D consecutive edges.
    bit lg0[$];
    bit lg1[$];
    bit m_lvl[2];
    bit m_rise[2];
    int m_run[2];

    function automatic void model_reset();
        lg0.delete();
        lg1.delete();
        for (int c = 0; c < 2; c++) begin
            m_lvl[c] = 1'b0;
            m_rise[c] = 1'b0;
            m_run[c] = 0;
        end
    endfunction

    function automatic void model_ch(int c, bit r);
        bit seen;
        int n;
        if (c == 0) begin
            n = lg0.size();
            seen = (n >= S) ? lg0[n-S] : 1'b0;
            lg0.push_back(r);
        end else begin
            n = lg1.size();
            seen = (n >= S) ? lg1[n-S] : 1'b0;
            lg1.push_back(r);
        end
        m_rise[c] = 1'b0;
        if (seen != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == D) begin
                m_lvl[c] = seen;
                m_rise[c] = seen;
                m_run[c] = 0;
            end
        end else begin
            m_run[c] = 0;
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(string tag);
        chk({tag, ".a"},     32'(ifc.a),     32'(m_lvl[0]));
        chk({tag, ".b"},     32'(ifc.b),     32'(m_lvl[1]));
        chk({tag, ".aRise"}, 32'(ifc.aRise), 32'(m_rise[0]));
        chk({tag, ".bRise"}, 32'(ifc.bRise), 32'(m_rise[1]));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_ch(0, ifc.aRaw);
        model_ch(1, ifc.bRaw);
        #1;
        cmp_all(tag);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".a"},     32'(ifc.a),     0);
        chk({tag, ".b"},     32'(ifc.b),     0);
        chk({tag, ".aRise"}, 32'(ifc.aRise), 0);
        chk({tag, ".bRise"}, 32'(ifc.bRise), 0);
    endtask

    // Called 1 time unit after a posedge; asserts reset mid-cycle, checks
    // outputs clear before any clock edge, releases on a falling edge.
    task automatic do_reset(string tag);
        #1 rstN = 1'b0;
        #1 chk_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
    endtask

    int npulse;
    int ha, hb;
    bit [8:0] bounce;

    initial begin
        rstN = 1'b1;
        ifc.aRaw = 1'b0;
        ifc.bRaw = 1'b0;
        model_reset();
        #2 rstN = 1'b0;
        #1 chk_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;

        // Clean rise on A: commit at t0+5, pulse gone at t0+6.
        ifc.aRaw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick("rise");
            if (k == 5) chk("rise_early.a", 32'(ifc.a), 0);
            if (k == 6) begin
                chk("rise_commit.a", 32'(ifc.a), 1);
                chk("rise_commit.aRise", 32'(ifc.aRise), 1);
            end
            if (k == 7) begin
                chk("rise_after.aRise", 32'(ifc.aRise), 0);
                chk("rise_after.a", 32'(ifc.a), 1);
            end
        end

        // Release A: falls at t0+5, no pulse.
        ifc.aRaw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick("fall");
            chk("fall.aRise", 32'(ifc.aRise), 0);
            if (k == 5) chk("fall_early.a", 32'(ifc.a), 1);
            if (k == 6) chk("fall_commit.a", 32'(ifc.a), 0);
        end

        // Bounce 1,0,1,1,0,1,1,1,1 then hold: commit only after the final run.
        bounce = 9'b111101101;
        npulse = 0;
        for (int k = 0; k < 14; k++) begin
            ifc.aRaw = (k < 9) ? bounce[k] : 1'b1;
            tick("bounce");
            if (ifc.aRise) npulse++;
            if (k == 9)  chk("bounce_early.a", 32'(ifc.a), 0);
            if (k == 10) chk("bounce_commit.a", 32'(ifc.a), 1);
        end
        chk("bounce_pulses", 32'(npulse), 1);
        ifc.aRaw = 1'b0;
        repeat (8) tick("bounce_rel");

        // Three-cycle glitch on B is rejected.
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            ifc.bRaw = (k < 3);
            tick("glitch");
            if (ifc.b || ifc.bRise) npulse++;
        end
        chk("glitch_activity", 32'(npulse), 0);

        // Simultaneous rise on both channels.
        ifc.aRaw = 1'b1;
        ifc.bRaw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick("both");
            if (k == 6) begin
                chk("both.a", 32'(ifc.a), 1);
                chk("both.b", 32'(ifc.b), 1);
                chk("both.aRise", 32'(ifc.aRise), 1);
                chk("both.bRise", 32'(ifc.bRise), 1);
            end
        end

        // Reset while both levels are high, raws still held.
        do_reset("rst_hi");
        for (int k = 1; k <= 7; k++) begin
            tick("rst_hi_rel");
            if (k == 5) chk("rst_hi_early.a", 32'(ifc.a), 0);
            if (k == 6) chk("rst_hi_commit.aRise", 32'(ifc.aRise), 1);
        end
        ifc.aRaw = 1'b0;
        ifc.bRaw = 1'b0;
        repeat (8) tick("rst_hi_drop");

        // Reset mid-count (count at 2), then full interval after release.
        ifc.aRaw = 1'b1;
        repeat (4) tick("midcnt");
        do_reset("rst_mid");
        for (int k = 1; k <= 7; k++) begin
            tick("rst_mid_rel");
            if (k == 5) chk("rst_mid_early.a", 32'(ifc.a), 0);
            if (k == 6) chk("rst_mid_commit.a", 32'(ifc.a), 1);
        end
        ifc.aRaw = 1'b0;
        repeat (8) tick("rst_mid_drop");

        // Randomized bouncing on both channels, with one reset in the middle.
        ha = 0;
        hb = 0;
        for (int k = 0; k < 1500; k++) begin
            if (ha == 0) begin
                ifc.aRaw = 1'($urandom_range(0, 1));
                ha = $urandom_range(1, 7);
            end
            if (hb == 0) begin
                ifc.bRaw = 1'($urandom_range(0, 1));
                hb = $urandom_range(1, 7);
            end
            ha--;
            hb--;
            tick("rand");
            if (k == 700) do_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
